// File: rtl/abus_sdram_pkg.sv
// Shared types and default constants for the A-Bus/Avalon SDRAM command arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package abus_sdram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RSP,
        REFRESH
    } state_t;

    typedef enum logic {
        OWN_ABUS,
        OWN_AVS
    } owner_t;

    localparam int DEF_ADDR_W         = 25;
    localparam int DEF_REFRESH_PERIOD = 900;
    localparam int DEF_MAX_ABUS_RUN   = 4;
    localparam int DATA_W             = 16;
    localparam int BE_W               = 2;

endpackage

// File: rtl/abus_sdram_refresh_timer.sv
// Free-running refresh interval counter with pending flag and sticky overrun flag.
// Latency: pending rises the cycle after the counter reaches zero.
// Backpressure: pending holds until refresh_ack; a second expiry while pending flags overrun.
module abus_sdram_refresh_timer
    import abus_sdram_pkg::*;
#(
    parameter int REFRESH_PERIOD = DEF_REFRESH_PERIOD
) (
    input  logic clock,
    input  logic reset,
    input  logic refresh_ack,
    output logic refresh_pending,
    output logic refresh_overrun
);

    localparam int CNT_W = $clog2(REFRESH_PERIOD + 1);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REFRESH_PERIOD - 1);

    logic [CNT_W-1:0] count;
    logic             tick;

    assign tick = (count == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            count           <= RELOAD;
            refresh_pending <= 1'b0;
            refresh_overrun <= 1'b0;
        end else begin
            count <= tick ? RELOAD : count - 1'b1;
            // A new period starting in the same cycle as an ack re-arms pending.
            if (tick) begin
                refresh_pending <= 1'b1;
                if (refresh_pending && !refresh_ack) begin
                    refresh_overrun <= 1'b1;
                end
            end else if (refresh_ack) begin
                refresh_pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/abus_sdram_arbiter.sv
// Serialises A-Bus and Avalon accesses plus auto-refresh onto one SDRAM command port.
// Latency: mem_valid one cycle after a request is seen idle; read data one cycle after mem_rvalid.
// Backpressure: requester waitrequest drops only in the cycle the engine takes its command.
module abus_sdram_arbiter
    import abus_sdram_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int REFRESH_PERIOD = DEF_REFRESH_PERIOD,
    parameter int MAX_ABUS_RUN   = DEF_MAX_ABUS_RUN
) (
    input  logic              clock,
    input  logic              reset,

    input  logic [ADDR_W-1:0] abus_address,
    input  logic              abus_read,
    input  logic              abus_write,
    input  logic [15:0]       abus_writedata,
    input  logic [1:0]        abus_byteenable,
    output logic              abus_waitrequest,
    output logic [15:0]       abus_readdata,
    output logic              abus_readdatavalid,

    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [15:0]       avs_writedata,
    input  logic [1:0]        avs_byteenable,
    output logic              avs_waitrequest,
    output logic [15:0]       avs_readdata,
    output logic              avs_readdatavalid,

    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_refresh,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [15:0]       mem_writedata,
    output logic [1:0]        mem_byteenable,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_rvalid,

    output logic              refresh_overrun
);

    localparam int RUN_W = $clog2(MAX_ABUS_RUN + 1);

    state_t           state;
    owner_t           owner;
    logic [RUN_W-1:0] abus_run;
    logic             abus_req;
    logic             avs_req;
    logic             grant_abus;
    logic             issue_accept;
    logic             refresh_ack;
    logic             refresh_pending;

    assign abus_req     = abus_read | abus_write;
    assign avs_req      = avs_read | avs_write;
    assign grant_abus   = abus_req && ((abus_run < RUN_W'(MAX_ABUS_RUN)) || !avs_req);
    assign issue_accept = (state == ISSUE) && mem_ready;
    assign refresh_ack  = (state == REFRESH) && mem_ready;

    // Combinational so the requester is released in the same cycle the engine accepts.
    assign abus_waitrequest = !(issue_accept && (owner == OWN_ABUS));
    assign avs_waitrequest  = !(issue_accept && (owner == OWN_AVS));

    abus_sdram_refresh_timer #(
        .REFRESH_PERIOD (REFRESH_PERIOD)
    ) u_refresh_timer (
        .clock           (clock),
        .reset           (reset),
        .refresh_ack     (refresh_ack),
        .refresh_pending (refresh_pending),
        .refresh_overrun (refresh_overrun)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= IDLE;
            owner              <= OWN_ABUS;
            abus_run           <= '0;
            mem_valid          <= 1'b0;
            mem_refresh        <= 1'b0;
            mem_write          <= 1'b0;
            mem_address        <= '0;
            mem_writedata      <= '0;
            mem_byteenable     <= '0;
            abus_readdata      <= '0;
            abus_readdatavalid <= 1'b0;
            avs_readdata       <= '0;
            avs_readdatavalid  <= 1'b0;
        end else begin
            abus_readdatavalid <= 1'b0;
            avs_readdatavalid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (refresh_pending) begin
                        mem_valid   <= 1'b1;
                        mem_refresh <= 1'b1;
                        mem_write   <= 1'b0;
                        state       <= REFRESH;
                    end else if (grant_abus) begin
                        owner          <= OWN_ABUS;
                        mem_valid      <= 1'b1;
                        mem_write      <= abus_write;
                        mem_address    <= abus_address;
                        mem_writedata  <= abus_writedata;
                        mem_byteenable <= abus_byteenable;
                        // Run length only matters while Avalon is actually waiting.
                        abus_run       <= avs_req ? abus_run + 1'b1 : '0;
                        state          <= ISSUE;
                    end else if (avs_req) begin
                        owner          <= OWN_AVS;
                        mem_valid      <= 1'b1;
                        mem_write      <= avs_write;
                        mem_address    <= avs_address;
                        mem_writedata  <= avs_writedata;
                        mem_byteenable <= avs_byteenable;
                        abus_run       <= '0;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        state     <= mem_write ? IDLE : WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (mem_rvalid) begin
                        if (owner == OWN_ABUS) begin
                            abus_readdata      <= mem_rdata;
                            abus_readdatavalid <= 1'b1;
                        end else begin
                            avs_readdata      <= mem_rdata;
                            avs_readdatavalid <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                REFRESH: begin
                    if (mem_ready) begin
                        mem_valid   <= 1'b0;
                        mem_refresh <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_abus_sdram_arbiter.sv
// Directed bench for abus_sdram_arbiter: vector table of single transactions plus
// hand-written sequences for arbitration fairness, refresh cadence, overrun and reset.
module tb_abus_sdram_arbiter;

    localparam int AW = 25;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] abus_address, avs_address;
    logic          abus_read, abus_write, avs_read, avs_write;
    logic [15:0]   abus_writedata, avs_writedata;
    logic [1:0]    abus_byteenable, avs_byteenable;
    logic          abus_waitrequest, avs_waitrequest;
    logic [15:0]   abus_readdata, avs_readdata;
    logic          abus_readdatavalid, avs_readdatavalid;
    logic          mem_valid, mem_ready, mem_refresh, mem_write;
    logic [AW-1:0] mem_address;
    logic [15:0]   mem_writedata, mem_rdata;
    logic [1:0]    mem_byteenable;
    logic          mem_rvalid;
    logic          refresh_overrun;

    always #5 clock = ~clock;

    abus_sdram_arbiter #(
        .ADDR_W         (AW),
        .REFRESH_PERIOD (16),
        .MAX_ABUS_RUN   (4)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .abus_address       (abus_address),
        .abus_read          (abus_read),
        .abus_write         (abus_write),
        .abus_writedata     (abus_writedata),
        .abus_byteenable    (abus_byteenable),
        .abus_waitrequest   (abus_waitrequest),
        .abus_readdata      (abus_readdata),
        .abus_readdatavalid (abus_readdatavalid),
        .avs_address        (avs_address),
        .avs_read           (avs_read),
        .avs_write          (avs_write),
        .avs_writedata      (avs_writedata),
        .avs_byteenable     (avs_byteenable),
        .avs_waitrequest    (avs_waitrequest),
        .avs_readdata       (avs_readdata),
        .avs_readdatavalid  (avs_readdatavalid),
        .mem_valid          (mem_valid),
        .mem_ready          (mem_ready),
        .mem_refresh        (mem_refresh),
        .mem_write          (mem_write),
        .mem_address        (mem_address),
        .mem_writedata      (mem_writedata),
        .mem_byteenable     (mem_byteenable),
        .mem_rdata          (mem_rdata),
        .mem_rvalid         (mem_rvalid),
        .refresh_overrun    (refresh_overrun)
    );

    typedef struct {
        logic          port_avs;
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [15:0]   wdata;
        logic [1:0]    be;
        logic [15:0]   rsp;
        int            dly;
        logic          exp_write;
        logic [15:0]   exp_rdata;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    int  abus_rdv_cnt = 0;
    int  avs_rdv_cnt  = 0;
    byte grant_q[$];
    int  ref_q[$];

    always @(posedge clock) cyc <= cyc + 1;

    // Observe accepted commands and read pulses away from the active edge.
    always @(negedge clock) begin
        if (abus_readdatavalid) abus_rdv_cnt = abus_rdv_cnt + 1;
        if (avs_readdatavalid)  avs_rdv_cnt  = avs_rdv_cnt + 1;
        if (!reset && mem_valid && mem_ready) begin
            if (mem_refresh)            ref_q.push_back(cyc);
            else if (!abus_waitrequest) grant_q.push_back("A");
            else if (!avs_waitrequest)  grant_q.push_back("V");
            else                        grant_q.push_back("X");
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        abus_address = '0; avs_address = '0;
        abus_read = 0; abus_write = 0; avs_read = 0; avs_write = 0;
        abus_writedata = '0; avs_writedata = '0;
        abus_byteenable = '0; avs_byteenable = '0;
        mem_ready = 1; mem_rvalid = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".abus_wr"}, 32'(abus_waitrequest), 1);
        check({tag, ".avs_wr"}, 32'(avs_waitrequest), 1);
        check({tag, ".abus_rdv"}, 32'(abus_readdatavalid), 0);
        check({tag, ".avs_rdv"}, 32'(avs_readdatavalid), 0);
        check({tag, ".abus_rd"}, 32'(abus_readdata), 0);
        check({tag, ".avs_rd"}, 32'(avs_readdata), 0);
        check({tag, ".mem_valid"}, 32'(mem_valid), 0);
        check({tag, ".mem_refresh"}, 32'(mem_refresh), 0);
        check({tag, ".mem_write"}, 32'(mem_write), 0);
        check({tag, ".mem_address"}, 32'(mem_address), 0);
        check({tag, ".mem_wdata"}, 32'(mem_writedata), 0);
        check({tag, ".mem_be"}, 32'(mem_byteenable), 0);
        check({tag, ".overrun"}, 32'(refresh_overrun), 0);
    endtask

    vec_t vecs[6];
    byte  exp_grants[10];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int a0, v0, g0, r0, n, t;
        logic own_wr, oth_wr;

        //          avs rd wr addr          wdata     be     rsp       dly wr exp_rdata
        vecs[0] = '{0, 0, 1, 25'h000_1234, 16'hBEEF, 2'b11, 16'h0000, 0, 1, 16'h0000};
        vecs[1] = '{1, 1, 0, 25'h000_0ABC, 16'h0000, 2'b11, 16'h5A5A, 3, 0, 16'h5A5A};
        vecs[2] = '{0, 1, 0, 25'h1FF_FFFF, 16'h0000, 2'b01, 16'hFFFF, 1, 0, 16'hFFFF};
        vecs[3] = '{1, 0, 1, 25'h000_0000, 16'h0001, 2'b01, 16'h0000, 0, 1, 16'h0000};
        vecs[4] = '{0, 1, 1, 25'h0AA_5555, 16'hC3C3, 2'b10, 16'h0000, 0, 1, 16'h0000};
        vecs[5] = '{1, 1, 1, 25'h155_AAAA, 16'h3C3C, 2'b11, 16'h0000, 0, 1, 16'h0000};
        exp_grants = '{"A", "A", "A", "A", "V", "A", "A", "A", "A", "V"};

        // Reset values while reset is held.
        idle_inputs();
        reset = 1;
        step();
        step();
        @(negedge clock);
        check_reset_outputs("reset");

        // Single transactions from the table.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            a0 = abus_rdv_cnt;
            v0 = avs_rdv_cnt;
            if (vecs[i].port_avs) begin
                avs_read = vecs[i].rd; avs_write = vecs[i].wr;
                avs_address = vecs[i].addr; avs_writedata = vecs[i].wdata;
                avs_byteenable = vecs[i].be;
            end else begin
                abus_read = vecs[i].rd; abus_write = vecs[i].wr;
                abus_address = vecs[i].addr; abus_writedata = vecs[i].wdata;
                abus_byteenable = vecs[i].be;
            end
            step();
            @(negedge clock);
            own_wr = vecs[i].port_avs ? avs_waitrequest : abus_waitrequest;
            oth_wr = vecs[i].port_avs ? abus_waitrequest : avs_waitrequest;
            check($sformatf("v%0d.mem_valid", i), 32'(mem_valid), 1);
            check($sformatf("v%0d.mem_refresh", i), 32'(mem_refresh), 0);
            check($sformatf("v%0d.mem_write", i), 32'(mem_write), 32'(vecs[i].exp_write));
            check($sformatf("v%0d.mem_address", i), 32'(mem_address), 32'(vecs[i].addr));
            check($sformatf("v%0d.mem_wdata", i), 32'(mem_writedata), 32'(vecs[i].wdata));
            check($sformatf("v%0d.mem_be", i), 32'(mem_byteenable), 32'(vecs[i].be));
            check($sformatf("v%0d.owner_wait", i), 32'(own_wr), 0);
            check($sformatf("v%0d.other_wait", i), 32'(oth_wr), 1);
            step();
            abus_read = 0; abus_write = 0; avs_read = 0; avs_write = 0;
            @(negedge clock);
            own_wr = vecs[i].port_avs ? avs_waitrequest : abus_waitrequest;
            check($sformatf("v%0d.valid_drop", i), 32'(mem_valid), 0);
            check($sformatf("v%0d.wait_back", i), 32'(own_wr), 1);
            if (!vecs[i].exp_write) begin
                repeat (vecs[i].dly - 1) step();
                mem_rvalid = 1;
                mem_rdata = vecs[i].rsp;
                step();
                mem_rvalid = 0;
                mem_rdata = '0;
                @(negedge clock);
                check($sformatf("v%0d.rdv", i),
                      32'(vecs[i].port_avs ? avs_readdatavalid : abus_readdatavalid), 1);
                check($sformatf("v%0d.rdata", i),
                      32'(vecs[i].port_avs ? avs_readdata : abus_readdata),
                      32'(vecs[i].exp_rdata));
            end
            step();
            step();
            check($sformatf("v%0d.abus_rdv_count", i), 32'(abus_rdv_cnt - a0),
                  32'((!vecs[i].port_avs && !vecs[i].exp_write) ? 1 : 0));
            check($sformatf("v%0d.avs_rdv_count", i), 32'(avs_rdv_cnt - v0),
                  32'((vecs[i].port_avs && !vecs[i].exp_write) ? 1 : 0));
        end

        // Stray mem_rvalid while idle must not produce read data.
        do_reset();
        a0 = abus_rdv_cnt;
        v0 = avs_rdv_cnt;
        mem_rvalid = 1;
        mem_rdata = 16'hDEAD;
        step();
        step();
        mem_rvalid = 0;
        step();
        step();
        check("stray_rvalid.abus", 32'(abus_rdv_cnt - a0), 0);
        check("stray_rvalid.avs", 32'(avs_rdv_cnt - v0), 0);

        // Both ports streaming writes: A-Bus run limited to four while Avalon waits.
        do_reset();
        g0 = grant_q.size();
        abus_write = 1; abus_address = 25'h000_1000; abus_writedata = 16'h1111; abus_byteenable = 2'b11;
        avs_write = 1; avs_address = 25'h000_2000; avs_writedata = 16'h2222; avs_byteenable = 2'b11;
        t = 0;
        while ((grant_q.size() - g0) < 10 && t < 80) begin
            step();
            t++;
        end
        if ((grant_q.size() - g0) < 10) check("grant_seq_timeout", 32'(grant_q.size() - g0), 10);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("grant[%0d]", k),
                  32'(((g0 + k) < grant_q.size()) ? grant_q[g0 + k] : 8'h00),
                  32'(exp_grants[k]));
        end
        idle_inputs();

        // Constant A-Bus stream: refresh slots in every 16 cycles.
        do_reset();
        r0 = ref_q.size();
        g0 = grant_q.size();
        abus_write = 1; abus_address = 25'h000_0042; abus_writedata = 16'h4242; abus_byteenable = 2'b11;
        repeat (100) step();
        n = ref_q.size() - r0;
        check("refresh.count_ge5", 32'(n >= 5), 1);
        check("refresh.abus_grants_ge40", 32'((grant_q.size() - g0) >= 40), 1);
        for (int k = 1; k < n; k++) begin
            check($sformatf("refresh.interval[%0d]", k), 32'(ref_q[r0 + k] - ref_q[r0 + k - 1]), 16);
        end
        check("refresh.no_overrun", 32'(refresh_overrun), 0);
        idle_inputs();

        // Engine stalled: second expiry while pending sets the sticky overrun.
        do_reset();
        mem_ready = 0;
        repeat (20) step();
        @(negedge clock);
        check("stall.refresh_valid", 32'(mem_valid), 1);
        check("stall.refresh_cmd", 32'(mem_refresh), 1);
        check("stall.overrun_early", 32'(refresh_overrun), 0);
        repeat (20) step();
        @(negedge clock);
        check("stall.overrun_set", 32'(refresh_overrun), 1);
        mem_ready = 1;
        repeat (5) step();
        @(negedge clock);
        check("stall.overrun_sticky", 32'(refresh_overrun), 1);
        check("stall.refresh_done", 32'(mem_valid), 0);
        reset = 1;
        step();
        @(negedge clock);
        check("stall.overrun_cleared", 32'(refresh_overrun), 0);

        // Reset while waiting for read data, with the response arriving in the same cycle.
        do_reset();
        avs_read = 1; avs_address = 25'h000_0F0F; avs_byteenable = 2'b11;
        step();
        step();
        avs_read = 0;
        a0 = abus_rdv_cnt;
        v0 = avs_rdv_cnt;
        reset = 1;
        mem_rvalid = 1;
        mem_rdata = 16'h1111;
        step();
        @(negedge clock);
        check_reset_outputs("rst_wait");
        step();
        reset = 0;
        mem_rvalid = 0;
        mem_rdata = '0;
        repeat (3) step();
        check("rst_wait.abus_rdv_count", 32'(abus_rdv_cnt - a0), 0);
        check("rst_wait.avs_rdv_count", 32'(avs_rdv_cnt - v0), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
